// File: rtl/arb_request_stage.sv
// arb_request_stage: two-channel request front-end (held requests, aged priority, hold timeout, release gap)
// Optional ARB_REQ_QUEUE_EN: one-deep pending request per channel, re-armed straight out of RELEASE.
module arb_request_stage #(
  parameter int AGE_CYCLES = 8,
  parameter int MAX_HOLD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       done_a,
  input  logic [1:0] base_pa,
  input  logic       req_b,
  input  logic       done_b,
  input  logic [1:0] base_pb,
  input  logic       ga,
  input  logic       gb,
  output logic       ra,
  output logic       rb,
  output logic [1:0] PA,
  output logic [1:0] PB,
  output logic       own_a,
  output logic       own_b,
  output logic       timeout_a,
  output logic       timeout_b
);
  localparam int AW = AGE_CYCLES > 1 ? $clog2(AGE_CYCLES) : 1;
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, OWN, RELEASE} state_t;
  logic       req_v[2], done_v[2], g_v[2];
  logic [1:0] base_v[2];
  logic       r_q[2], own_q[2], to_q[2];
  logic [1:0] p_q[2];
  assign req_v[0]  = req_a;
  assign req_v[1]  = req_b;
  assign done_v[0] = done_a;
  assign done_v[1] = done_b;
  assign g_v[0]    = ga;
  assign g_v[1]    = gb;
  assign base_v[0] = base_pa;
  assign base_v[1] = base_pb;
  assign ra        = r_q[0];
  assign rb        = r_q[1];
  assign PA        = p_q[0];
  assign PB        = p_q[1];
  assign own_a     = own_q[0];
  assign own_b     = own_q[1];
  assign timeout_a = to_q[0];
  assign timeout_b = to_q[1];
  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t        st, st_n;
    logic [AW-1:0] age, age_n;
    logic [HW-1:0] hold, hold_n;
    logic [1:0]    p_n;
    logic          to_n;
`ifdef ARB_REQ_QUEUE_EN
    logic          pend, pend_n;
`endif
    always_comb begin
      st_n   = st;
      age_n  = age;
      hold_n = hold;
      p_n    = p_q[c];
      to_n   = 1'b0;
`ifdef ARB_REQ_QUEUE_EN
      pend_n = pend | (req_v[c] && st != IDLE);
`endif
      case (st)
        IDLE:
          if (req_v[c]) begin
            st_n  = WAIT;
            p_n   = base_v[c];
            age_n = '0;
          end
        WAIT:
          if (done_v[c]) begin
            st_n = IDLE;
            p_n  = '0;
`ifdef ARB_REQ_QUEUE_EN
            pend_n = 1'b0;
`endif
          end else if (g_v[c]) begin
            st_n   = OWN;
            hold_n = '0;
          end else if (age == AW'(AGE_CYCLES - 1)) begin
            age_n = '0;
            p_n   = p_q[c] == 2'd3 ? 2'd3 : p_q[c] + 2'd1;
          end else begin
            age_n = age + 1'b1;
          end
        OWN:
          if (done_v[c] || hold == HW'(MAX_HOLD - 1)) begin
            st_n = RELEASE;
            p_n  = '0;
            to_n = ~done_v[c];
          end else begin
            hold_n = hold + 1'b1;
          end
        default: begin
          st_n = IDLE;
`ifdef ARB_REQ_QUEUE_EN
          // a req arriving during the release cycle itself is queued too
          if (pend_n) begin
            st_n   = WAIT;
            p_n    = base_v[c];
            age_n  = '0;
            pend_n = 1'b0;
          end
`endif
        end
      endcase
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st       <= IDLE;
        age      <= '0;
        hold     <= '0;
        p_q[c]   <= '0;
        r_q[c]   <= 1'b0;
        own_q[c] <= 1'b0;
        to_q[c]  <= 1'b0;
      end else begin
        st       <= st_n;
        age      <= age_n;
        hold     <= hold_n;
        p_q[c]   <= p_n;
        r_q[c]   <= st_n == WAIT || st_n == OWN;
        own_q[c] <= st_n == OWN;
        to_q[c]  <= to_n;
      end
    end
`ifdef ARB_REQ_QUEUE_EN
    always_ff @(posedge clk) pend <= rst ? 1'b0 : pend_n;
`endif
  end
endmodule

// File: tb/tb_arb_request_stage.sv
// tb_arb_request_stage: directed scoreboard bench for arb_request_stage (AGE_CYCLES=8, MAX_HOLD=16)
module tb_arb_request_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, done_a = 1'b0, req_b = 1'b0, done_b = 1'b0, ga = 1'b0, gb = 1'b0;
  logic [1:0] base_pa = '0, base_pb = '0;
  logic       ra, rb, own_a, own_b, timeout_a, timeout_b;
  logic [1:0] PA, PB;
  int         n_assert = 0;
  int         n_fail = 0;
  typedef struct {
    string      tag;
    logic [9:0] exp;
    logic [9:0] mask;
  } sb_t;
  sb_t sb[$];
  localparam logic [9:0] FULL = 10'h3ff;
  localparam logic [9:0] MRO  = 10'b11_0000_1100;
  arb_request_stage #(.AGE_CYCLES(8), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .done_a(done_a), .base_pa(base_pa),
    .req_b(req_b), .done_b(done_b), .base_pb(base_pb),
    .ga(ga), .gb(gb),
    .ra(ra), .rb(rb), .PA(PA), .PB(PB),
    .own_a(own_a), .own_b(own_b), .timeout_a(timeout_a), .timeout_b(timeout_b)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] o(input logic r_a, input logic r_b, input logic [1:0] p_a,
                                   input logic [1:0] p_b, input logic o_a, input logic o_b,
                                   input logic t_a, input logic t_b);
    return {r_a, r_b, p_a, p_b, o_a, o_b, t_a, t_b};
  endfunction
  task automatic cyc(input string tag, input logic [9:0] exp, input logic [9:0] mask = FULL);
    sb_t        e;
    logic [9:0] obs;
    sb.push_back('{tag, exp, mask});
    @(posedge clk);
    @(negedge clk);
    e   = sb.pop_front();
    obs = {ra, rb, PA, PB, own_a, own_b, timeout_a, timeout_b};
    n_assert++;
    assert ((obs & e.mask) === (e.exp & e.mask))
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b (mask %b)", e.tag, obs, e.exp, e.mask);
    end
  endtask
  initial begin
    cyc("rst0", '0);
    cyc("rst1", '0);
    rst = 1'b0;
    cyc("post_rst", '0);
    ga = 1'b1;
    cyc("spurious_ga_idle", '0);
    ga = 1'b0;
    req_a = 1'b1; base_pa = 2'd1;
    cyc("s2_req", o(1, 0, 1, 0, 0, 0, 0, 0));
    req_a = 1'b0; ga = 1'b1;
    cyc("s2_grant", o(1, 0, 1, 0, 1, 0, 0, 0));
    cyc("s2_own1", o(1, 0, 1, 0, 1, 0, 0, 0));
    cyc("s2_own2", o(1, 0, 1, 0, 1, 0, 0, 0));
    done_a = 1'b1;
    cyc("s2_release", '0);
    done_a = 1'b0; ga = 1'b0;
    cyc("s2_idle", '0);
    done_a = 1'b1;
    cyc("s2_done_in_idle", '0);
    done_a = 1'b0;
    req_b = 1'b1; base_pb = 2'd0;
    cyc("s3_req", o(0, 1, 0, 0, 0, 0, 0, 0));
    req_b = 1'b0;
    for (int i = 1; i <= 30; i++)
      cyc($sformatf("s3_age%0d", i), o(0, 1, 0, i < 8 ? 2'd0 : i < 16 ? 2'd1 : i < 24 ? 2'd2 : 2'd3, 0, 0, 0, 0));
    gb = 1'b1;
    cyc("s3_grant", o(0, 1, 0, 3, 0, 1, 0, 0));
    gb = 1'b0; done_b = 1'b1;
    cyc("s3_release", '0);
    done_b = 1'b0;
    cyc("s3_idle", '0);
    req_a = 1'b1; base_pa = 2'd2;
    cyc("s4_req", o(1, 0, 2, 0, 0, 0, 0, 0));
    req_a = 1'b0; ga = 1'b1;
    for (int i = 0; i < 16; i++) cyc($sformatf("s4_own%0d", i), o(1, 0, 2, 0, 1, 0, 0, 0));
    cyc("s4_timeout", o(0, 0, 0, 0, 0, 0, 1, 0));
    ga = 1'b0;
    cyc("s4_idle", '0);
    req_a = 1'b1; base_pa = 2'd1;
    cyc("s5_req", o(1, 0, 1, 0, 0, 0, 0, 0));
    req_a = 1'b0; done_a = 1'b1; ga = 1'b1;
    cyc("s5_abort", '0, MRO);
    done_a = 1'b0;
    cyc("s5_ga_after_abort", '0, MRO);
    ga = 1'b0;
    req_a = 1'b1; base_pa = 2'd3;
    cyc("s6_req", o(1, 0, 3, 0, 0, 0, 0, 0));
    req_a = 1'b0; ga = 1'b1;
    cyc("s6_grant", o(1, 0, 3, 0, 1, 0, 0, 0));
    req_a = 1'b1; base_pa = 2'd2;
    cyc("s6_req_in_own", o(1, 0, 3, 0, 1, 0, 0, 0));
    req_a = 1'b0; done_a = 1'b1;
    cyc("s6_release", '0);
    done_a = 1'b0; ga = 1'b0; base_pa = 2'd1;
`ifdef ARB_REQ_QUEUE_EN
    cyc("s6_requeued", o(1, 0, 1, 0, 0, 0, 0, 0));
    done_a = 1'b1;
    cyc("s6_abort_requeued", '0, MRO);
    done_a = 1'b0;
`else
    cyc("s6_not_requeued", '0);
    cyc("s6_still_idle", '0);
`endif
    req_b = 1'b1; done_b = 1'b1; base_pb = 2'd2;
    cyc("s7_req_and_done_idle", o(0, 1, 0, 2, 0, 0, 0, 0), 10'b01_0011_0101);
    req_b = 1'b0; done_b = 1'b0;
    req_a = 1'b1; base_pa = 2'd1;
    cyc("s7_both_wait", o(1, 1, 1, 2, 0, 0, 0, 0));
    req_a = 1'b0; ga = 1'b1;
    cyc("s7_a_own", o(1, 1, 1, 2, 1, 0, 0, 0));
    rst = 1'b1;
    cyc("s7_rst_mid_own", '0);
    rst = 1'b0; ga = 1'b0;
    cyc("s7_after_rst", '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
